// File: rtl/mem_wb_pipe_stage.sv
// MEM->WB pipeline register: valid/ready handshake, optional 2-entry skid,
// synchronous flush, writeback value mux and saturating stall counter.
module mem_wb_pipe_stage #(
  parameter int DATA_W  = 32,
  parameter int DEST_W  = 4,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wb_en,
  input  logic              in_mem_r_en,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wb_en,
  output logic              out_mem_r_en,
  output logic [DATA_W-1:0] out_alu_res,
  output logic [DATA_W-1:0] out_mem_data,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr,
  output logic [DEST_W-1:0] out_dest,
  output logic [DATA_W-1:0] wb_value,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              wb_en;
    logic              mem_r_en;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic [DEST_W-1:0] dest;
  } entry_t;

  entry_t in_ent;
  entry_t main_q;
  entry_t main_d;
  entry_t skid_q;
  logic   main_valid;
  logic   main_valid_d;
  logic   skid_valid;
  logic   skid_valid_d;
  logic   main_load;
  logic   skid_load;
  logic   accept;
  logic   pop;

  assign in_ent = '{wb_en: in_wb_en, mem_r_en: in_mem_r_en, alu_res: in_alu_res,
                    mem_data: in_mem_data, pc: in_pc, instr: in_instr, dest: in_dest};

  assign accept = in_valid && in_ready;
  assign pop    = main_valid && out_ready;

  always_comb begin
    main_valid_d = main_valid;
    skid_valid_d = skid_valid;
    main_load    = 1'b0;
    skid_load    = 1'b0;
    main_d       = in_ent;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid) begin
      if (accept) begin
        main_load    = 1'b1;
        main_valid_d = 1'b1;
      end
    end else if (pop) begin
      if (skid_valid) begin
        main_load = 1'b1;
        main_d    = skid_q;
        if (accept) skid_load    = 1'b1;
        else        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_load = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      // only reachable with a skid: without one in_ready is low here
      skid_load    = 1'b1;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid <= 1'b0;
      main_q     <= '0;
    end else begin
      main_valid <= main_valid_d;
      if (main_load) main_q <= main_d;
    end
  end

  generate
    if (SKID_EN != 0) begin : g_skid
      logic in_ready_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          skid_valid <= 1'b0;
          skid_q     <= '0;
          in_ready_q <= 1'b0;
        end else begin
          skid_valid <= skid_valid_d;
          if (skid_load) skid_q <= in_ent;
          in_ready_q <= !skid_valid_d;
        end
      end

      assign in_ready = in_ready_q;
    end else begin : g_no_skid
      logic ready_en_q;
      logic unused_skid;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) ready_en_q <= 1'b0;
        else      ready_en_q <= 1'b1;
      end

      assign skid_valid  = 1'b0;
      assign skid_q      = '0;
      assign unused_skid = skid_valid_d | skid_load;
      assign in_ready    = ready_en_q && (!main_valid || out_ready);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid    = main_valid;
  assign out_wb_en    = main_q.wb_en && main_valid;
  assign out_mem_r_en = main_q.mem_r_en;
  assign out_alu_res  = main_q.alu_res;
  assign out_mem_data = main_q.mem_data;
  assign out_pc       = main_q.pc;
  assign out_instr    = main_q.instr;
  assign out_dest     = main_q.dest;
  assign wb_value     = main_q.mem_r_en ? main_q.mem_data : main_q.alu_res;

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Directed bench for mem_wb_pipe_stage: a skid instance (SKID_EN=1, CNT_W=16)
// and a no-skid instance (SKID_EN=0, CNT_W=2) sharing clock and reset.
module tb_mem_wb_pipe_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // instance A: skid buffer
  logic        a_flush = 0, a_in_valid = 0, a_in_ready, a_in_wb_en = 0, a_in_mem_r_en = 0;
  logic [31:0] a_in_alu = 0, a_in_mem = 0, a_in_pc = 0, a_in_instr = 0;
  logic [3:0]  a_in_dest = 0;
  logic        a_out_valid, a_out_ready = 0, a_out_wb_en, a_out_mem_r_en;
  logic [31:0] a_out_alu, a_out_mem, a_out_pc, a_out_instr, a_wb_value;
  logic [3:0]  a_out_dest;
  logic [15:0] a_stall;

  // instance B: no skid, 2-bit counter
  logic        b_flush = 0, b_in_valid = 0, b_in_ready, b_in_wb_en = 0, b_in_mem_r_en = 0;
  logic [31:0] b_in_alu = 0, b_in_mem = 0, b_in_pc = 0, b_in_instr = 0;
  logic [3:0]  b_in_dest = 0;
  logic        b_out_valid, b_out_ready = 0, b_out_wb_en, b_out_mem_r_en;
  logic [31:0] b_out_alu, b_out_mem, b_out_pc, b_out_instr, b_wb_value;
  logic [3:0]  b_out_dest;
  logic [1:0]  b_stall;

  mem_wb_pipe_stage #(.DATA_W(32), .DEST_W(4), .SKID_EN(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_wb_en(a_in_wb_en),
    .in_mem_r_en(a_in_mem_r_en), .in_alu_res(a_in_alu), .in_mem_data(a_in_mem),
    .in_pc(a_in_pc), .in_instr(a_in_instr), .in_dest(a_in_dest),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_wb_en(a_out_wb_en),
    .out_mem_r_en(a_out_mem_r_en), .out_alu_res(a_out_alu), .out_mem_data(a_out_mem),
    .out_pc(a_out_pc), .out_instr(a_out_instr), .out_dest(a_out_dest),
    .wb_value(a_wb_value), .stall_cnt(a_stall)
  );

  mem_wb_pipe_stage #(.DATA_W(32), .DEST_W(4), .SKID_EN(0), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_wb_en(b_in_wb_en),
    .in_mem_r_en(b_in_mem_r_en), .in_alu_res(b_in_alu), .in_mem_data(b_in_mem),
    .in_pc(b_in_pc), .in_instr(b_in_instr), .in_dest(b_in_dest),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_wb_en(b_out_wb_en),
    .out_mem_r_en(b_out_mem_r_en), .out_alu_res(b_out_alu), .out_mem_data(b_out_mem),
    .out_pc(b_out_pc), .out_instr(b_out_instr), .out_dest(b_out_dest),
    .wb_value(b_wb_value), .stall_cnt(b_stall)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", a_out_valid); end
    n_cmp++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready_held got=%b want=0", a_in_ready); end
    n_cmp++; if (a_wb_value !== 32'h0) begin n_err++; $display("FAIL reset_wb_value got=%h want=0", a_wb_value); end
    rst = 1'b1;
    step();
    n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_a_in_ready_after got=%b want=1", a_in_ready); end
    n_cmp++; if (b_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_b_in_ready_after got=%b want=1", b_in_ready); end
    // fill A with two loads under backpressure, then reset mid-stream
    a_out_ready = 0; a_in_valid = 1; a_in_mem_r_en = 1; a_in_mem = 32'h55; a_in_pc = 32'h40;
    step();
    a_in_pc = 32'h44;
    step();
    a_in_valid = 0;
    step();
    n_cmp++; if (a_out_valid !== 1'b1 || a_wb_value !== 32'h55) begin n_err++; $display("FAIL pre_reset_head got=%b/%h want=1/00000055", a_out_valid, a_wb_value); end
    n_cmp++; if (a_stall !== 16'd2) begin n_err++; $display("FAIL pre_reset_stall got=%0d want=2", a_stall); end
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL midreset_out_valid got=%b want=0", a_out_valid); end
    n_cmp++; if (a_stall !== 16'd0) begin n_err++; $display("FAIL midreset_stall got=%0d want=0", a_stall); end
    n_cmp++; if (a_wb_value !== 32'h0) begin n_err++; $display("FAIL midreset_wb_value got=%h want=0", a_wb_value); end
    a_in_mem_r_en = 0; a_in_mem = 0; a_out_ready = 1;
    @(posedge clk);
    #1 rst = 1'b1;
    step();
    n_cmp++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin n_err++; $display("FAIL post_reset got ready=%b valid=%b want 1/0", a_in_ready, a_out_valid); end
  endtask

  task automatic test_stream();
    a_out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      a_in_valid = 1; a_in_pc = 32'(i * 4);
      n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready[%0d] got=%b want=1", i, a_in_ready); end
      step();
      n_cmp++;
      if (a_out_valid !== 1'b1 || a_out_pc !== 32'(i * 4)) begin
        n_err++; $display("FAIL stream_out[%0d] got valid=%b pc=%h want 1/%h", i, a_out_valid, a_out_pc, 32'(i * 4));
      end
    end
    a_in_valid = 0;
    step();
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain got=%b want=0", a_out_valid); end
    n_cmp++; if (a_stall !== 16'd0) begin n_err++; $display("FAIL stream_stall got=%0d want=0", a_stall); end
  endtask

  task automatic test_backpressure();
    a_out_ready = 0; a_in_valid = 1; a_in_pc = 32'h100;
    step();
    n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_after_a got=%b want=1", a_in_ready); end
    a_in_pc = 32'h104;
    step();
    a_in_valid = 0;
    n_cmp++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_after_b got=%b want=0", a_in_ready); end
    n_cmp++; if (a_out_pc !== 32'h100) begin n_err++; $display("FAIL bp_head_a got=%h want=00000100", a_out_pc); end
    repeat (3) step();
    n_cmp++; if (a_stall !== 16'd4) begin n_err++; $display("FAIL bp_stall got=%0d want=4", a_stall); end
    n_cmp++; if (a_out_valid !== 1'b1 || a_out_pc !== 32'h100) begin n_err++; $display("FAIL bp_hold got=%b/%h want 1/00000100", a_out_valid, a_out_pc); end
    a_out_ready = 1;
    step();
    n_cmp++; if (a_out_valid !== 1'b1 || a_out_pc !== 32'h104) begin n_err++; $display("FAIL bp_pop_b got=%b/%h want 1/00000104", a_out_valid, a_out_pc); end
    n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_reopen got=%b want=1", a_in_ready); end
    step();
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty got=%b want=0", a_out_valid); end
    n_cmp++; if (a_stall !== 16'd4) begin n_err++; $display("FAIL bp_stall_hold got=%0d want=4", a_stall); end
  endtask

  task automatic test_flush();
    a_out_ready = 0; a_in_valid = 1; a_in_wb_en = 1; a_in_pc = 32'h200;
    step();
    a_in_pc = 32'h204;
    step();
    n_cmp++; if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin n_err++; $display("FAIL flush_full got valid=%b ready=%b want 1/0", a_out_valid, a_in_ready); end
    a_flush = 1; a_out_ready = 1; a_in_pc = 32'h208;
    step();
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got=%b want=0", a_out_valid); end
    n_cmp++; if (a_out_wb_en !== 1'b0) begin n_err++; $display("FAIL flush_wb_en got=%b want=0", a_out_wb_en); end
    n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready got=%b want=1", a_in_ready); end
    n_cmp++; if (a_stall !== 16'd5) begin n_err++; $display("FAIL flush_stall got=%0d want=5", a_stall); end
    // one held entry, flush while an accept is possible
    a_flush = 0; a_out_ready = 0; a_in_pc = 32'h20C;
    step();
    a_flush = 1; a_out_ready = 1; a_in_pc = 32'h210;
    step();
    a_flush = 0; a_in_valid = 0;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_beats_accept got=%b want=0", a_out_valid); end
    step();
    step();
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_ghost got=%b pc=%h want=0", a_out_valid, a_out_pc); end
    n_cmp++; if (a_stall !== 16'd5) begin n_err++; $display("FAIL flush_stall_kept got=%0d want=5", a_stall); end
    a_in_wb_en = 0;
  endtask

  task automatic test_mux();
    a_out_ready = 1; a_in_valid = 1; a_in_wb_en = 1; a_in_mem_r_en = 1;
    a_in_mem = 32'hDEADBEEF; a_in_alu = 32'h10; a_in_dest = 4'd5;
    step();
    n_cmp++; if (a_wb_value !== 32'hDEADBEEF) begin n_err++; $display("FAIL mux_load got=%h want=deadbeef", a_wb_value); end
    n_cmp++; if (a_out_wb_en !== 1'b1 || a_out_dest !== 4'd5) begin n_err++; $display("FAIL mux_load_ctl got wb_en=%b dest=%0d want 1/5", a_out_wb_en, a_out_dest); end
    a_in_mem_r_en = 0; a_in_dest = 4'd6;
    step();
    n_cmp++; if (a_wb_value !== 32'h10) begin n_err++; $display("FAIL mux_alu got=%h want=00000010", a_wb_value); end
    n_cmp++; if (a_out_mem_r_en !== 1'b0 || a_out_dest !== 4'd6) begin n_err++; $display("FAIL mux_alu_ctl got r_en=%b dest=%0d want 0/6", a_out_mem_r_en, a_out_dest); end
    a_in_valid = 0; a_in_wb_en = 0;
    step();
    n_cmp++; if (a_out_valid !== 1'b0 || a_out_wb_en !== 1'b0) begin n_err++; $display("FAIL mux_idle got valid=%b wb_en=%b want 0/0", a_out_valid, a_out_wb_en); end
  endtask

  task automatic test_random_noskid();
    int unsigned exp_q[$];
    int sent = 0;
    int recvd = 0;
    int unsigned k;
    for (int cyc = 0; cyc < 2000 && recvd < 50; cyc++) begin
      if (cyc < 5)         b_out_ready = 0;
      else if (sent == 50) b_out_ready = 1;
      else                 b_out_ready = 1'($urandom_range(0, 1));
      b_in_valid = (sent < 50);
      b_in_pc    = 32'(sent * 4);
      b_in_alu   = 32'(sent + 32'h1000);
      #1;
      if (b_out_valid && b_out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL noskid_extra got pc=%h want no entry", b_out_pc);
        end else begin
          k = exp_q.pop_front();
          if (b_out_pc !== 32'(k * 4) || b_wb_value !== 32'(k + 32'h1000)) begin
            n_err++; $display("FAIL noskid_order got pc=%h wb=%h want %h/%h", b_out_pc, b_wb_value, 32'(k * 4), 32'(k + 32'h1000));
          end
        end
        recvd++;
      end
      if (b_in_valid && b_in_ready) begin
        exp_q.push_back(sent);
        sent++;
      end
      @(posedge clk);
      #1;
    end
    b_in_valid = 0;
    n_cmp++; if (recvd != 50) begin n_err++; $display("FAIL noskid_count got=%0d want=50", recvd); end
    n_cmp++; if (b_stall !== 2'd3) begin n_err++; $display("FAIL noskid_stall_sat got=%0d want=3", b_stall); end
    step();
    n_cmp++; if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL noskid_drain got=%b want=0", b_out_valid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_mux();
    test_random_noskid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
